seg7_scan: RTL and testbench

- Downstream consumer of the 32-bit LED output register: takes the 32-bit word written by the CPU and drives the board's 8-digit common-anode seven-segment display.
- Time-multiplexes the display as 8 hex digits with per-digit blanking to suppress ghosting.
- Latches its input only at frame boundaries, so a CPU write mid-scan never produces a torn display.
- Sits between the LED/IO output register and the board pins.

---
 rtl/seg7_scan_pkg.sv | 50 +++++
 rtl/seg7_scan_hex_to_seg7.sv | 18 +
 rtl/seg7_scan.sv | 112 +++++++++++
 tb/tb_seg7_scan.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seven-segment scanner.
//   DIGITS   : number of multiplexed digits
//   SEG_OFF  : all segments dark (active-low)
//   AN_OFF   : all anodes off (active-low)
//   hex_code : nibble -> active-low segment code {dp,g,f,e,d,c,b,a}, dp off
package seg7_scan_pkg;

   localparam int         DIGITS  = 8;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   localparam logic [7:0] HEX_0 = 8'hC0;
   localparam logic [7:0] HEX_1 = 8'hF9;
   localparam logic [7:0] HEX_2 = 8'hA4;
   localparam logic [7:0] HEX_3 = 8'hB0;
   localparam logic [7:0] HEX_4 = 8'h99;
   localparam logic [7:0] HEX_5 = 8'h92;
   localparam logic [7:0] HEX_6 = 8'h82;
   localparam logic [7:0] HEX_7 = 8'hF8;
   localparam logic [7:0] HEX_8 = 8'h80;
   localparam logic [7:0] HEX_9 = 8'h90;
   localparam logic [7:0] HEX_A = 8'h88;
   localparam logic [7:0] HEX_B = 8'h83;
   localparam logic [7:0] HEX_C = 8'hC6;
   localparam logic [7:0] HEX_D = 8'hA1;
   localparam logic [7:0] HEX_E = 8'h86;
   localparam logic [7:0] HEX_F = 8'h8E;

   function automatic logic [7:0] hex_code(input logic [3:0] nib);
      case (nib)
         4'h0: hex_code = HEX_0;
         4'h1: hex_code = HEX_1;
         4'h2: hex_code = HEX_2;
         4'h3: hex_code = HEX_3;
         4'h4: hex_code = HEX_4;
         4'h5: hex_code = HEX_5;
         4'h6: hex_code = HEX_6;
         4'h7: hex_code = HEX_7;
         4'h8: hex_code = HEX_8;
         4'h9: hex_code = HEX_9;
         4'hA: hex_code = HEX_A;
         4'hB: hex_code = HEX_B;
         4'hC: hex_code = HEX_C;
         4'hD: hex_code = HEX_D;
         4'hE: hex_code = HEX_E;
         default: hex_code = HEX_F;
      endcase
   endfunction

endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// Combinational nibble + decimal point -> active-low segment pattern.
//   nib : hex digit value
//   dp  : decimal point, 1 = lit
//   seg : {dp,g,f,e,d,c,b,a}, active-low
module hex_to_seg7
   import seg7_scan_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] code;

   assign code = hex_code(nib);
   assign seg  = {~dp, code[6:0]};

endmodule

// File: rtl/seg7_scan.sv
// 8-digit common-anode seven-segment scanner.
// Shows the 32-bit segdata as 8 hex digits, one digit per SCAN_DIV-cycle slot,
// with BLANK_CYC all-off cycles at the start of each slot against ghosting.
// Inputs are captured into shadow registers only at the frame boundary so a
// mid-scan write never tears the display.
//   seg_clk    : display clock
//   segrst     : synchronous active-high reset
//   segdata    : nibble i -> digit i (digit 0 rightmost)
//   segdp      : decimal point per digit, 1 = lit
//   segmask    : digit enable, 1 = may light
//   segmode    : 0 = plain hex, 1 = leading-zero blanking
//   seg_an     : anodes, active-low
//   seg_out    : segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick : one-cycle pulse in the cycle the shadow holds new data
module seg7_scan
   import seg7_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        seg_clk,
   input  logic        segrst,
   input  logic [31:0] segdata,
   input  logic [7:0]  segdp,
   input  logic [7:0]  segmask,
   input  logic        segmode,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_out,
   output logic        frame_tick
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] BLANK_W  = DW'(BLANK_CYC);

   logic [DW-1:0]     div_cnt;
   logic [2:0]        idx;
   logic [31:0]       sh_data;
   logic [7:0]        sh_dp;
   logic [7:0]        sh_mask;
   logic              sh_mode;

   logic              slot_end;
   logic              frame_end;
   logic              in_blank;
   logic [DIGITS-1:0] vis;
   logic [3:0]        cur_nib;
   logic [7:0]        cur_seg;
   logic [7:0]        an_code;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == 3'd7);

   // With no blanking the compare would be constant-false; drop it entirely.
   if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
   end else begin : g_blank
      assign in_blank = (div_cnt < BLANK_W);
   end

   // Leading-zero blanking: digit i goes dark when every nibble from 7 down
   // to i is zero. Digit 0 is exempt so a zero value still shows "0".
   for (genvar i = 0; i < DIGITS; i++) begin : g_vis
      if (i == 0) begin : g_d0
         assign vis[i] = sh_mask[i];
      end else begin : g_dn
         assign vis[i] = sh_mask[i] & (~sh_mode | (|sh_data[31:4*i]));
      end
   end

   assign cur_nib = sh_data[{idx, 2'b00} +: 4];
   assign an_code = ~(8'd1 << idx);

   hex_to_seg7 u_hex (
      .nib (cur_nib),
      .dp  (sh_dp[idx]),
      .seg (cur_seg)
   );

   always_ff @(posedge seg_clk) begin
      if (segrst) begin
         div_cnt    <= '0;
         idx        <= '0;
         sh_data    <= '0;
         sh_dp      <= '0;
         sh_mask    <= '0;
         sh_mode    <= 1'b0;
         seg_an     <= AN_OFF;
         seg_out    <= SEG_OFF;
         frame_tick <= 1'b0;
      end else begin
         div_cnt    <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end) idx <= idx + 3'd1;   // 3-bit wrap 7 -> 0
         frame_tick <= frame_end;
         if (frame_end) begin
            sh_data <= segdata;
            sh_dp   <= segdp;
            sh_mask <= segmask;
            sh_mode <= segmode;
         end
         // Outputs reflect this cycle's (idx, div_cnt): one cycle of latency.
         if (in_blank || !vis[idx]) begin
            seg_an  <= AN_OFF;
            seg_out <= SEG_OFF;
         end else begin
            seg_an  <= an_code;
            seg_out <= cur_seg;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (SCAN_DIV=4/BLANK_CYC=1 and
// SCAN_DIV=2/BLANK_CYC=0) share inputs and are compared every cycle against
// a time-based model: cycle count since reset -> slot/digit/phase.
module tb_seg7_scan;

   logic        seg_clk = 1'b0;
   logic        segrst;
   logic [31:0] segdata;
   logic [7:0]  segdp, segmask;
   logic        segmode;
   logic [7:0]  an_a, out_a, an_b, out_b;
   logic        tick_a, tick_b;

   int checks = 0;
   int errors = 0;

   always #5 seg_clk = ~seg_clk;

   seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut_a (
      .seg_clk(seg_clk), .segrst(segrst), .segdata(segdata), .segdp(segdp),
      .segmask(segmask), .segmode(segmode), .seg_an(an_a), .seg_out(out_a),
      .frame_tick(tick_a));

   seg7_scan #(.SCAN_DIV(2), .BLANK_CYC(0)) dut_b (
      .seg_clk(seg_clk), .segrst(segrst), .segdata(segdata), .segdp(segdp),
      .segmask(segmask), .segmode(segmode), .seg_an(an_b), .seg_out(out_b),
      .frame_tick(tick_b));

   // ---------------- reference model ----------------
   int          sd [2] = '{4, 2};
   int          bl [2] = '{1, 0};
   int          t  [2];
   logic [31:0] m_data [2];
   logic [7:0]  m_dp [2], m_mask [2];
   logic        m_mode [2];
   logic [7:0]  e_an [2], e_out [2];
   logic        e_tick [2];
   logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Advance model c across one clock edge using the inputs about to be sampled.
   task automatic model_edge(input int c);
      int ph, d, nib;
      bit vis;
      logic [7:0] code;
      if (segrst) begin
         t[c] = 0; m_data[c] = '0; m_dp[c] = '0; m_mask[c] = '0; m_mode[c] = 1'b0;
         e_an[c] = 8'hFF; e_out[c] = 8'hFF; e_tick[c] = 1'b0;
      end else begin
         ph  = t[c] % sd[c];
         d   = (t[c] / sd[c]) % 8;
         nib = int'((m_data[c] >> (4 * d)) & 32'hF);
         vis = m_mask[c][d] && (!m_mode[c] || d == 0 || (m_data[c] >> (4 * d)) != 0);
         if (ph < bl[c] || !vis) begin
            e_an[c] = 8'hFF; e_out[c] = 8'hFF;
         end else begin
            code     = hex_tab[nib];
            e_an[c]  = ~(8'h01 << d);
            e_out[c] = {~m_dp[c][d], code[6:0]};
         end
         e_tick[c] = (ph == sd[c] - 1) && (d == 7);
         if (e_tick[c]) begin
            m_data[c] = segdata; m_dp[c] = segdp; m_mask[c] = segmask; m_mode[c] = segmode;
         end
         t[c] = (t[c] + 1) % (8 * sd[c]);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      model_edge(0);
      model_edge(1);
      @(posedge seg_clk);
      #1;
      chk("an_a",   an_a,           e_an[0]);
      chk("out_a",  out_a,          e_out[0]);
      chk("tick_a", {7'd0, tick_a}, {7'd0, e_tick[0]});
      chk("an_b",   an_b,           e_an[1]);
      chk("out_b",  out_b,          e_out[1]);
      chk("tick_b", {7'd0, tick_b}, {7'd0, e_tick[1]});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int first_tick;
      int n;

      segrst = 1'b1; segdata = 32'h0; segdp = 8'h0; segmask = 8'h0; segmode = 1'b0;
      #1;
      run(2);
      chk("reset_an",  an_a,  8'hFF);
      chk("reset_out", out_a, 8'hFF);

      // First frame stays dark; first frame_tick after exactly 32 cycles.
      segrst = 1'b0; segdata = 32'h12345678; segmask = 8'hFF;
      first_tick = -1;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if (tick_a && first_tick < 0) first_tick = i;
      end
      chk_int("first_tick_cycle", first_tick, 32);

      // Mid-frame write is held off until the next frame boundary.
      run(5);
      segdata = 32'hFFFFFFFF;
      run(70);

      // Leading-zero blanking.
      segmode = 1'b1; segdata = 32'h000000A0;
      run(70);
      segdata = 32'h0;
      run(70);

      // Masked digit 0 with dp requested stays dark.
      segmode = 1'b0; segdp = 8'h01; segmask = 8'hFE;
      run(70);

      // Reset at slot cycle 2 of digit 5 on the SCAN_DIV=4 instance.
      segdata = 32'hCAFE1234; segdp = 8'h5A; segmask = 8'hFF;
      run(40);
      n = 0;
      while (t[0] != 22 && n < 64) begin cycle(); n++; end
      chk_int("reset_align", t[0], 22);
      segrst = 1'b1;
      cycle();
      chk("midrst_an",  an_a,  8'hFF);
      chk("midrst_out", out_a, 8'hFF);
      segrst = 1'b0;
      run(40);

      // Randomized traffic, occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) segdata = $urandom;
         if ($urandom_range(0, 15) == 0) segdata = $urandom >> (4 * $urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) segdp = 8'($urandom);
         if ($urandom_range(0, 15) == 0) segmask = 8'($urandom);
         if ($urandom_range(0, 15) == 0) segmode = 1'($urandom);
         segrst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      segrst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
